// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scan_ctrl
//  Purpose  : 4x4 keypad sweep, press/release debounce and two-digit key
//             history for the seven-segment display driver.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old,
    output logic       busy
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] S_SCAN      = 2'd0;
    localparam logic [1:0] S_DEB_PRESS = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_DEB_REL   = 2'd3;

    logic [1:0]     state, state_nxt;
    logic [1:0]     row_idx, row_nxt;
    logic [1:0]     lock_col, lock_nxt;
    logic [DW-1:0]  dwell, dwell_nxt;
    logic [DBW-1:0] deb_cnt, deb_nxt;
    logic           valid_nxt;
    logic [3:0]     code_nxt, new_nxt, old_nxt;
    logic [1:0]     first_low;
    logic [3:0]     key_map;

    // Hex legend of the keypad, indexed by {row, column}.
    function automatic logic [3:0] map_key(input logic [3:0] idx);
        logic [3:0] v;
        case (idx)
            4'd0:    v = 4'h1;
            4'd1:    v = 4'h2;
            4'd2:    v = 4'h3;
            4'd3:    v = 4'hA;
            4'd4:    v = 4'h4;
            4'd5:    v = 4'h5;
            4'd6:    v = 4'h6;
            4'd7:    v = 4'hB;
            4'd8:    v = 4'h7;
            4'd9:    v = 4'h8;
            4'd10:   v = 4'h9;
            4'd11:   v = 4'hC;
            4'd12:   v = 4'hE;
            4'd13:   v = 4'h0;
            4'd14:   v = 4'hF;
            default: v = 4'hD;
        endcase
        return v;
    endfunction

    // Lowest-index active column wins when several are pressed in one row.
    always_comb begin
        if (!cols[0])      first_low = 2'd0;
        else if (!cols[1]) first_low = 2'd1;
        else if (!cols[2]) first_low = 2'd2;
        else               first_low = 2'd3;
    end

    assign key_map = map_key({row_idx, lock_col});

    // Next-state logic for the sweep/debounce FSM and the key history.
    always_comb begin
        state_nxt = state;
        row_nxt   = row_idx;
        lock_nxt  = lock_col;
        dwell_nxt = dwell;
        deb_nxt   = deb_cnt;
        valid_nxt = 1'b0;
        code_nxt  = key_code;
        new_nxt   = digit_new;
        old_nxt   = digit_old;
        case (state)
            S_SCAN: begin
                // Columns are only trusted at the end of the dwell so the
                // newly driven row has had time to settle.
                if (dwell == DWELL_LAST) begin
                    dwell_nxt = '0;
                    if (cols == 4'hF) begin
                        row_nxt = row_idx + 2'd1;
                    end else begin
                        lock_nxt  = first_low;
                        deb_nxt   = '0;
                        state_nxt = S_DEB_PRESS;
                    end
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
            end
            S_DEB_PRESS: begin
                if (cols[lock_col]) begin
                    // Bounce: rescan the same row from a fresh dwell.
                    dwell_nxt = '0;
                    state_nxt = S_SCAN;
                end else if (deb_cnt == DEB_LAST) begin
                    valid_nxt = 1'b1;
                    code_nxt  = key_map;
                    new_nxt   = key_map;
                    old_nxt   = digit_new;
                    state_nxt = S_HELD;
                end else begin
                    deb_nxt = deb_cnt + DBW'(1);
                end
            end
            S_HELD: begin
                if (cols == 4'hF) begin
                    deb_nxt   = '0;
                    state_nxt = S_DEB_REL;
                end
            end
            S_DEB_REL: begin
                if (cols != 4'hF) begin
                    state_nxt = S_HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    row_nxt   = row_idx + 2'd1;
                    dwell_nxt = '0;
                    state_nxt = S_SCAN;
                end else begin
                    deb_nxt = deb_cnt + DBW'(1);
                end
            end
            default: state_nxt = S_SCAN;
        endcase
    end

    // State and output registers; rows and busy are derived from next state
    // so they stay registered yet track row_idx and state without lag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_SCAN;
            row_idx   <= 2'd0;
            lock_col  <= 2'd0;
            dwell     <= '0;
            deb_cnt   <= '0;
            rows      <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_nxt;
            lock_col  <= lock_nxt;
            dwell     <= dwell_nxt;
            deb_cnt   <= deb_nxt;
            rows      <= ~(4'b0001 << row_nxt);
            key_valid <= valid_nxt;
            key_code  <= code_nxt;
            digit_new <= new_nxt;
            digit_old <= old_nxt;
            busy      <= (state_nxt != S_SCAN);
        end
    end

endmodule
`default_nettype wire
